// File: rtl/ioctl_download_tx.sv
// Streams a byte source into the ioctl download bus: one strobed write per byte,
// with a programmable idle gap between writes and core back-pressure via ioctl_wait.
module ioctl_download_tx #(
    parameter int unsigned WR_GAP = 3
) (
    input  logic        clk_48,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  index,
    input  logic [24:0] length,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    input  logic        ioctl_wait,
    output logic        ioctl_download,
    output logic [7:0]  ioctl_index,
    output logic        ioctl_wr,
    output logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_dout,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        FETCH  = 3'd2,
        HOLD   = 3'd3,
        STROBE = 3'd4,
        GAP    = 3'd5,
        FINISH = 3'd6
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'((WR_GAP > 0) ? WR_GAP - 1 : 0);

    state_t      state;
    logic [24:0] len_q;
    logic [24:0] byte_cnt;
    logic [24:0] cnt_next;
    logic [7:0]  gap_cnt;

    assign cnt_next  = byte_cnt + 25'd1;
    assign state_dbg = state;

    // Source handshake: a byte moves when s_valid and s_ready are both high at a
    // rising edge; s_ready is a registered flag that is high exactly while in FETCH.
    always_ff @(posedge clk_48) begin
        if (reset) begin
            state          <= IDLE;
            len_q          <= '0;
            byte_cnt       <= '0;
            gap_cnt        <= '0;
            s_ready        <= 1'b0;
            ioctl_download <= 1'b0;
            ioctl_index    <= '0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= '0;
            ioctl_dout     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            ioctl_wr <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != 25'd0) begin
                            len_q          <= length;
                            ioctl_index    <= index;
                            byte_cnt       <= '0;
                            ioctl_addr     <= '0;
                            ioctl_download <= 1'b1;
                            busy           <= 1'b1;
                            state          <= SETUP;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    s_ready <= 1'b1;
                    state   <= FETCH;
                end
                FETCH: begin
                    if (s_valid) begin
                        ioctl_dout <= s_data;
                        s_ready    <= 1'b0;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (!ioctl_wait) begin
                        ioctl_wr <= 1'b1;
                        state    <= STROBE;
                    end
                end
                STROBE: begin
                    byte_cnt <= cnt_next;
                    if (cnt_next == len_q) begin
                        // Address stays on the last written offset once the transfer ends.
                        state <= FINISH;
                    end else begin
                        ioctl_addr <= ioctl_addr + 25'd1;
                        if (WR_GAP == 0) begin
                            s_ready <= 1'b1;
                            state   <= FETCH;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        s_ready <= 1'b1;
                        state   <= FETCH;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                FINISH: begin
                    ioctl_download <= 1'b0;
                    busy           <= 1'b0;
                    done           <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ioctl_download_tx.sv
// Directed bench for ioctl_download_tx (WR_GAP=3): normal transfer, stalls,
// zero length, ignored restart and mid-transfer reset.
module tb_ioctl_download_tx;

    logic        clk_48 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  index = '0;
    logic [24:0] length = '0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic        ioctl_wait = 1'b0;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        busy;
    logic        done;
    logic [2:0]  state_dbg;

    ioctl_download_tx #(.WR_GAP(3)) dut (
        .clk_48(clk_48), .reset(reset), .start(start), .index(index), .length(length),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .ioctl_wait(ioctl_wait),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk_48 = ~clk_48;

    int cyc = 0;
    always @(posedge clk_48) cyc <= cyc + 1;

    // ---------------- monitor log ----------------
    logic [24:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          dl_cnt = 0;
    int          busy_cnt = 0;
    int          wr_no_dl = 0;

    always @(negedge clk_48) begin
        if (ioctl_wr) begin
            wr_addr_q.push_back(ioctl_addr);
            wr_data_q.push_back(ioctl_dout);
            wr_cyc_q.push_back(cyc);
            if (!ioctl_download) wr_no_dl <= wr_no_dl + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (ioctl_download) dl_cnt <= dl_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    // ---------------- scoreboard state ----------------
    logic [32:0] exp_q[$];
    logic [7:0]  src_q[$];
    bit          src_pause = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          t0 = 0;

    // ---------------- driver tasks ----------------
    task automatic step();
        logic hs;
        hs = s_valid && s_ready;
        @(posedge clk_48);
        #1;
        if (hs) void'(src_q.pop_front());
        if (src_q.size() > 0 && !src_pause) begin
            s_valid = 1'b1;
            s_data  = src_q[0];
        end else begin
            s_valid = 1'b0;
            s_data  = '0;
        end
    endtask

    task automatic load_src(input logic [7:0] base, input int n);
        src_q.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            src_q.push_back(base + 8'(i));
            exp_q.push_back({25'(i), base + 8'(i)});
        end
    endtask

    task automatic start_xfer(input logic [7:0] idx, input logic [24:0] len);
        index  = idx;
        length = len;
        start  = 1'b1;
        step();
        start  = 1'b0;
        t0     = cyc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({ioctl_download, ioctl_wr, s_ready, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000", {ioctl_download, ioctl_wr, s_ready, busy, done});
        end
        checks++;
        if ({ioctl_addr, ioctl_dout, ioctl_index} !== 41'd0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h dout=%h index=%h expected all 0", ioctl_addr, ioctl_dout, ioctl_index);
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d expected 0", state_dbg);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int n0, d0;
        n0 = wr_addr_q.size();
        d0 = done_cnt;
        load_src(8'hA0, 4);
        start_xfer(8'h01, 25'd4);
        checks++;
        if ({ioctl_download, busy, ioctl_index} !== {2'b11, 8'h01}) begin
            failures++;
            $display("FAIL basic_setup: got dl=%b busy=%b index=%h expected 1 1 01", ioctl_download, busy, ioctl_index);
        end
        for (int i = 0; i < 200 && done_cnt == d0; i++) step();
        checks++;
        if (wr_addr_q.size() - n0 !== 4) begin
            failures++;
            $display("FAIL basic_count: got %0d writes expected 4", wr_addr_q.size() - n0);
        end
        for (int i = 0; i < 4 && n0 + i < wr_addr_q.size(); i++) begin
            checks++;
            if ({wr_addr_q[n0+i], wr_data_q[n0+i]} !== exp_q[i]) begin
                failures++;
                $display("FAIL basic_write%0d: got %h/%h expected %h", i, wr_addr_q[n0+i], wr_data_q[n0+i], exp_q[i]);
            end
            checks++;
            if (wr_cyc_q[n0+i] !== t0 + 3 + 6 * i) begin
                failures++;
                $display("FAIL basic_timing%0d: got cycle %0d expected %0d", i, wr_cyc_q[n0+i], t0 + 3 + 6 * i);
            end
        end
        checks++;
        if (done_cnt !== d0 + 1 || done_cyc !== t0 + 23) begin
            failures++;
            $display("FAIL basic_done: got count=%0d cycle=%0d expected 1 at %0d", done_cnt - d0, done_cyc, t0 + 23);
        end
        step();
        checks++;
        if ({ioctl_download, busy, done, ioctl_addr} !== {3'b000, 25'd3}) begin
            failures++;
            $display("FAIL basic_after: got dl=%b busy=%b done=%b addr=%h expected 0 0 0 3", ioctl_download, busy, done, ioctl_addr);
        end
    endtask

    task automatic test_wait();
        int n0, d0, h;
        n0 = wr_addr_q.size();
        d0 = done_cnt;
        load_src(8'hB0, 4);
        start_xfer(8'h02, 25'd4);
        for (int i = 0; i < 100 && !(state_dbg == 3'd3 && ioctl_addr == 25'd2); i++) step();
        h = cyc;
        ioctl_wait = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({ioctl_wr, ioctl_addr, ioctl_dout} !== {1'b0, 25'd2, 8'hB2}) begin
                failures++;
                $display("FAIL wait_hold%0d: got wr=%b addr=%h dout=%h expected 0 2 b2", i, ioctl_wr, ioctl_addr, ioctl_dout);
            end
        end
        ioctl_wait = 1'b0;
        step();
        checks++;
        if ({ioctl_wr, ioctl_addr, ioctl_dout} !== {1'b1, 25'd2, 8'hB2} || cyc !== h + 11) begin
            failures++;
            $display("FAIL wait_release: got wr=%b addr=%h dout=%h expected 1 2 b2", ioctl_wr, ioctl_addr, ioctl_dout);
        end
        for (int i = 0; i < 200 && done_cnt == d0; i++) step();
        checks++;
        if (wr_addr_q.size() - n0 !== 4 || done_cnt !== d0 + 1) begin
            failures++;
            $display("FAIL wait_count: got writes=%0d dones=%0d expected 4 1", wr_addr_q.size() - n0, done_cnt - d0);
        end
        for (int i = 0; i < 4 && n0 + i < wr_addr_q.size(); i++) begin
            checks++;
            if ({wr_addr_q[n0+i], wr_data_q[n0+i]} !== exp_q[i]) begin
                failures++;
                $display("FAIL wait_write%0d: got %h/%h expected %h", i, wr_addr_q[n0+i], wr_data_q[n0+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_src_stall();
        int n0, d0;
        n0 = wr_addr_q.size();
        d0 = done_cnt;
        load_src(8'hC0, 3);
        start_xfer(8'h03, 25'd3);
        for (int i = 0; i < 100 && !(state_dbg == 3'd2 && ioctl_addr == 25'd1); i++) step();
        src_pause = 1'b1;
        s_valid   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({s_ready, ioctl_wr} !== 2'b10) begin
                failures++;
                $display("FAIL stall_fetch%0d: got s_ready=%b wr=%b expected 1 0", i, s_ready, ioctl_wr);
            end
            step();
        end
        src_pause = 1'b0;
        s_valid   = 1'b1;
        s_data    = src_q[0];
        for (int i = 0; i < 200 && done_cnt == d0; i++) step();
        checks++;
        if (wr_addr_q.size() - n0 !== 3) begin
            failures++;
            $display("FAIL stall_count: got %0d writes expected 3", wr_addr_q.size() - n0);
        end
        for (int i = 0; i < 3 && n0 + i < wr_addr_q.size(); i++) begin
            checks++;
            if ({wr_addr_q[n0+i], wr_data_q[n0+i]} !== exp_q[i]) begin
                failures++;
                $display("FAIL stall_write%0d: got %h/%h expected %h", i, wr_addr_q[n0+i], wr_data_q[n0+i], exp_q[i]);
            end
        end
        if (wr_addr_q.size() - n0 >= 2) begin
            checks++;
            if (wr_cyc_q[n0+1] - wr_cyc_q[n0] !== 11) begin
                failures++;
                $display("FAIL stall_gap: got %0d cycles expected 11", wr_cyc_q[n0+1] - wr_cyc_q[n0]);
            end
        end
    endtask

    task automatic test_zero_len();
        int n0, dl0, b0;
        n0  = wr_addr_q.size();
        dl0 = dl_cnt;
        b0  = busy_cnt;
        start_xfer(8'h44, 25'd0);
        checks++;
        if ({done, busy, ioctl_download} !== 3'b100) begin
            failures++;
            $display("FAIL zero_done: got done=%b busy=%b dl=%b expected 1 0 0", done, busy, ioctl_download);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL zero_pulse: got done=%b expected 0", done);
        end
        repeat (5) step();
        checks++;
        if (dl_cnt !== dl0 || busy_cnt !== b0 || wr_addr_q.size() !== n0) begin
            failures++;
            $display("FAIL zero_quiet: got dl=%0d busy=%0d wr=%0d expected 0 0 0", dl_cnt - dl0, busy_cnt - b0, wr_addr_q.size() - n0);
        end
    endtask

    task automatic test_restart_ignored();
        int n0, d0;
        n0 = wr_addr_q.size();
        d0 = done_cnt;
        load_src(8'hF0, 3);
        start_xfer(8'h33, 25'd3);
        repeat (4) step();
        index  = 8'h77;
        length = 25'd9;
        start  = 1'b1;
        step();
        start  = 1'b0;
        checks++;
        if (ioctl_index !== 8'h33) begin
            failures++;
            $display("FAIL restart_index: got %h expected 33", ioctl_index);
        end
        for (int i = 0; i < 200 && done_cnt == d0; i++) step();
        repeat (10) step();
        checks++;
        if (wr_addr_q.size() - n0 !== 3 || done_cnt !== d0 + 1) begin
            failures++;
            $display("FAIL restart_count: got writes=%0d dones=%0d expected 3 1", wr_addr_q.size() - n0, done_cnt - d0);
        end
        for (int i = 0; i < 3 && n0 + i < wr_addr_q.size(); i++) begin
            checks++;
            if ({wr_addr_q[n0+i], wr_data_q[n0+i]} !== exp_q[i]) begin
                failures++;
                $display("FAIL restart_write%0d: got %h/%h expected %h", i, wr_addr_q[n0+i], wr_data_q[n0+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n0, d0, n1;
        n0 = wr_addr_q.size();
        d0 = done_cnt;
        load_src(8'hD0, 8);
        start_xfer(8'h08, 25'd8);
        for (int i = 0; i < 100 && wr_addr_q.size() - n0 < 2; i++) step();
        reset = 1'b1;
        src_q.delete();
        s_valid = 1'b0;
        step();
        reset = 1'b0;
        checks++;
        if ({ioctl_download, ioctl_wr, s_ready, busy, done, ioctl_addr, ioctl_dout, ioctl_index} !== 46'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got dl=%b wr=%b rdy=%b busy=%b done=%b addr=%h dout=%h idx=%h expected all 0",
                     ioctl_download, ioctl_wr, s_ready, busy, done, ioctl_addr, ioctl_dout, ioctl_index);
        end
        n1 = wr_addr_q.size();
        repeat (20) step();
        checks++;
        if (wr_addr_q.size() !== n1 || n1 - n0 !== 2 || done_cnt !== d0) begin
            failures++;
            $display("FAIL midreset_quiet: got writes=%0d dones=%0d expected 2 0", wr_addr_q.size() - n0, done_cnt - d0);
        end
        load_src(8'hE0, 2);
        start_xfer(8'h5A, 25'd2);
        for (int i = 0; i < 100 && done_cnt == d0; i++) step();
        checks++;
        if (wr_addr_q.size() - n1 !== 2 || done_cnt !== d0 + 1) begin
            failures++;
            $display("FAIL midreset_restart: got writes=%0d dones=%0d expected 2 1", wr_addr_q.size() - n1, done_cnt - d0);
        end
        for (int i = 0; i < 2 && n1 + i < wr_addr_q.size(); i++) begin
            checks++;
            if ({wr_addr_q[n1+i], wr_data_q[n1+i]} !== exp_q[i]) begin
                failures++;
                $display("FAIL midreset_write%0d: got %h/%h expected %h", i, wr_addr_q[n1+i], wr_data_q[n1+i], exp_q[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_src_stall();
        test_zero_len();
        test_restart_ignored();
        test_reset_mid();
        step();
        checks++;
        if (wr_no_dl !== 0) begin
            failures++;
            $display("FAIL wr_without_download: got %0d strobes expected 0", wr_no_dl);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
